// File: rtl/vi_pattern_gen.sv
// vi_pattern_gen: raster timing generator plus four test patterns
// (solid, colour bars, gray ramp, scrolling checkerboard) that feeds
// the video-input side of the pipeline. mode/color are shadowed at
// frame boundaries so mid-frame changes never tear a frame.
module vi_pattern_gen #(
    parameter int H_DISP      = 1280,
    parameter int H_FRONT     = 110,
    parameter int H_SYNC      = 40,
    parameter int H_BACK      = 220,
    parameter int V_DISP      = 720,
    parameter int V_FRONT     = 5,
    parameter int V_SYNC      = 5,
    parameter int V_BACK      = 20,
    parameter int CHECK_SHIFT = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        EN,
    input  logic [1:0]  mode,
    input  logic [15:0] color,
    output logic        vs,
    output logic        hs,
    output logic        de,
    output logic [15:0] data,
    output logic [7:0]  frame_cnt
);
    localparam int H_TOTAL = H_SYNC + H_BACK + H_DISP + H_FRONT;
    localparam int V_TOTAL = V_SYNC + V_BACK + V_DISP + V_FRONT;
    localparam int H_START = H_SYNC + H_BACK;
    localparam int V_START = V_SYNC + V_BACK;
    localparam int BAR_W   = H_DISP / 8;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int XW      = (H_DISP > 1) ? $clog2(H_DISP) : 1;
    localparam int YW      = (V_DISP > 1) ? $clog2(V_DISP) : 1;
    localparam int BCW     = (BAR_W > 1) ? $clog2(BAR_W) : 1;

    typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

    state_t          r_state, w_state_nxt;
    logic [HW-1:0]   r_h_cnt;
    logic [VW-1:0]   r_v_cnt;
    logic [1:0]      r_sh_mode;
    logic [15:0]     r_sh_color;
    logic [7:0]      r_frame_cnt;
    logic [2:0]      r_bar_idx;
    logic [BCW-1:0]  r_bar_cnt;
    logic            r_vs, r_hs, r_de;
    logic [15:0]     r_data;

    logic            w_frame_end, w_latch, w_h_last;
    logic            w_h_act, w_v_act, w_de;
    logic [XW-1:0]   w_x, w_xs;
    logic [YW-1:0]   w_y;
    logic [5:0]      w_g6;
    logic            w_cx, w_cy;
    logic [15:0]     w_bar, w_pix;

    assign w_h_last = (r_h_cnt == HW'(H_TOTAL - 1));

    // Run control: next state and when to (re)capture the shadows
    always_comb begin
        w_state_nxt = r_state;
        w_frame_end = 1'b0;
        w_latch     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (EN) begin
                    w_state_nxt = S_RUN;
                    w_latch     = 1'b1;
                end
            end
            S_RUN: begin
                w_frame_end = w_h_last && (r_v_cnt == VW'(V_TOTAL - 1));
                if (w_frame_end) begin
                    if (EN) w_latch     = 1'b1;
                    else    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Raster counters; held at 0 while idle and restarted at frame end
    always_ff @(posedge clk) begin
        if (!rst_n || r_state == S_IDLE || w_frame_end) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (w_h_last) begin
            r_h_cnt <= '0;
            r_v_cnt <= r_v_cnt + VW'(1);
        end else begin
            r_h_cnt <= r_h_cnt + HW'(1);
        end
    end

    // Shadowed pattern configuration, captured only at frame boundaries
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sh_mode  <= 2'b00;
            r_sh_color <= 16'h0000;
        end else if (w_latch) begin
            r_sh_mode  <= mode;
            r_sh_color <= color;
        end
    end

    // Completed-frame counter, bumped on the frame-end edge itself
    always_ff @(posedge clk) begin
        if (!rst_n)           r_frame_cnt <= 8'd0;
        else if (w_frame_end) r_frame_cnt <= r_frame_cnt + 8'd1;
    end

    assign w_h_act = (r_h_cnt >= HW'(H_START)) && (r_h_cnt < HW'(H_START + H_DISP));
    assign w_v_act = (r_v_cnt >= VW'(V_START)) && (r_v_cnt < VW'(V_START + V_DISP));
    assign w_de    = w_h_act && w_v_act;
    assign w_x     = XW'(r_h_cnt - HW'(H_START));
    assign w_y     = YW'(r_v_cnt - VW'(V_START));

    // Bar index: zero outside the active part of a line, so it is clear
    // on the first pixel; saturates at 7 so the last bar takes the remainder
    always_ff @(posedge clk) begin
        if (!rst_n || r_state == S_IDLE || !w_h_act) begin
            r_bar_idx <= 3'd0;
            r_bar_cnt <= '0;
        end else if (r_bar_cnt == BCW'(BAR_W - 1)) begin
            r_bar_cnt <= '0;
            if (r_bar_idx != 3'd7) r_bar_idx <= r_bar_idx + 3'd1;
        end else begin
            r_bar_cnt <= r_bar_cnt + BCW'(1);
        end
    end

    // Bar colour lookup
    always_comb begin
        w_bar = 16'h0000;
        case (r_bar_idx)
            3'd0: w_bar = 16'hFFFF;
            3'd1: w_bar = 16'hFFE0;
            3'd2: w_bar = 16'h07FF;
            3'd3: w_bar = 16'h07E0;
            3'd4: w_bar = 16'hF81F;
            3'd5: w_bar = 16'hF800;
            3'd6: w_bar = 16'h001F;
            default: w_bar = 16'h0000;
        endcase
    end

    // Gray ramp uses x[7:2]; checkerboard sum wraps at x's own width
    assign w_g6 = 6'(8'(w_x) >> 2);
    assign w_xs = w_x + XW'(r_frame_cnt);
    assign w_cx = |((w_xs >> CHECK_SHIFT) & XW'(1));
    assign w_cy = |((w_y >> CHECK_SHIFT) & YW'(1));

    // Pattern select from the shadowed mode
    always_comb begin
        w_pix = 16'h0000;
        case (r_sh_mode)
            2'b00: w_pix = r_sh_color;
            2'b01: w_pix = w_bar;
            2'b10: w_pix = {w_g6[5:1], w_g6, w_g6[5:1]};
            default: w_pix = (w_cx ^ w_cy) ? 16'h0000 : 16'hFFFF;
        endcase
    end

    // Registered video outputs, one cycle behind the counters
    always_ff @(posedge clk) begin
        if (!rst_n || r_state == S_IDLE) begin
            r_vs   <= 1'b0;
            r_hs   <= 1'b0;
            r_de   <= 1'b0;
            r_data <= 16'h0000;
        end else begin
            r_vs   <= (r_v_cnt < VW'(V_SYNC));
            r_hs   <= (r_h_cnt < HW'(H_SYNC));
            r_de   <= w_de;
            r_data <= w_de ? w_pix : 16'h0000;
        end
    end

    assign vs        = r_vs;
    assign hs        = r_hs;
    assign de        = r_de;
    assign data      = r_data;
    assign frame_cnt = r_frame_cnt;

endmodule

// File: tb/tb_vi_pattern_gen.sv
// Bench for vi_pattern_gen: two small rasters (16x4 and 18x8 active)
// checked every cycle against a position-based raster model, plus a
// captured-pixel vector table and directed sequences.
module tb_vi_pattern_gen;
    localparam int HS = 2, HB = 2, HF = 2, VS = 1, VB = 1, VF = 1, CS = 2;
    localparam int HD0 = 16, VD0 = 4, HD1 = 18, VD1 = 8;

    typedef struct packed {
        logic        vs;
        logic        hs;
        logic        de;
        logic [15:0] data;
        logic [7:0]  fc;
    } out_t;

    typedef struct {
        logic [1:0]  mode;
        int          inst;
        int          fr;
        int          x;
        int          y;
        logic [15:0] exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        EN = 1'b0;
    logic [1:0]  mode = 2'b00;
    logic [15:0] color = 16'h0000;

    logic        vs0, hs0, de0, vs1, hs1, de1;
    logic [15:0] data0, data1;
    logic [7:0]  fc0, fc1;
    out_t        act [2];

    assign act[0] = {vs0, hs0, de0, data0, fc0};
    assign act[1] = {vs1, hs1, de1, data1, fc1};

    always #5 clk = ~clk;

    vi_pattern_gen #(.H_DISP(HD0), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
                     .V_DISP(VD0), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
                     .CHECK_SHIFT(CS)) dut0 (
        .clk(clk), .rst_n(rst_n), .EN(EN), .mode(mode), .color(color),
        .vs(vs0), .hs(hs0), .de(de0), .data(data0), .frame_cnt(fc0));

    vi_pattern_gen #(.H_DISP(HD1), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
                     .V_DISP(VD1), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
                     .CHECK_SHIFT(CS)) dut1 (
        .clk(clk), .rst_n(rst_n), .EN(EN), .mode(mode), .color(color),
        .vs(vs1), .hs(hs1), .de(de1), .data(data1), .frame_cnt(fc1));

    // ---------------- reference model ----------------
    function automatic logic [15:0] bar_color(int i);
        case (i)
            0: return 16'hFFFF;
            1: return 16'hFFE0;
            2: return 16'h07FF;
            3: return 16'h07E0;
            4: return 16'hF81F;
            5: return 16'hF800;
            6: return 16'h001F;
            default: return 16'h0000;
        endcase
    endfunction

    function automatic int hdisp(int inst); return inst ? HD1 : HD0; endfunction
    function automatic int vdisp(int inst); return inst ? VD1 : VD0; endfunction
    function automatic int flen(int inst);
        return (HS + HB + hdisp(inst) + HF) * (VS + VB + vdisp(inst) + VF);
    endfunction

    // Outputs for raster position pos of a running frame
    function automatic out_t raster(int inst, int pos, logic [1:0] m, logic [15:0] c, logic [7:0] fc);
        int hd, vd, xw, ht, h, v, x, y, g, s, bi;
        out_t o;
        hd = hdisp(inst);
        vd = vdisp(inst);
        xw = inst ? 5 : 4;
        ht = HS + HB + hd + HF;
        h  = pos % ht;
        v  = pos / ht;
        x  = h - (HS + HB);
        y  = v - (VS + VB);
        o  = '0;
        o.vs = (v < VS);
        o.hs = (h < HS);
        o.de = (x >= 0) && (x < hd) && (y >= 0) && (y < vd);
        if (o.de) begin
            case (m)
                2'd0: o.data = c;
                2'd1: begin
                    bi = x / (hd / 8);
                    o.data = bar_color(bi > 7 ? 7 : bi);
                end
                2'd2: begin
                    g = x % 256;
                    o.data = 16'(((g >> 3) << 11) | ((g >> 2) << 5) | (g >> 3));
                end
                default: begin
                    s = (x + int'(fc)) % (1 << xw);
                    o.data = (((s >> CS) ^ (y >> CS)) & 1) != 0 ? 16'h0000 : 16'hFFFF;
                end
            endcase
        end
        return o;
    endfunction

    bit          run [2];
    int          pos [2];
    logic [1:0]  sm  [2];
    logic [15:0] sc  [2];
    logic [7:0]  mfc [2];
    out_t        expv[2];

    initial begin
        for (int i = 0; i < 2; i++) begin
            run[i] = 0; pos[i] = 0; sm[i] = '0; sc[i] = '0; mfc[i] = '0; expv[i] = '0;
        end
    end

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                run[i] = 0; pos[i] = 0; sm[i] = '0; sc[i] = '0; mfc[i] = '0; expv[i] = '0;
            end else begin
                expv[i] = run[i] ? raster(i, pos[i], sm[i], sc[i], mfc[i]) : '0;
                if (!run[i]) begin
                    if (EN) begin run[i] = 1; pos[i] = 0; sm[i] = mode; sc[i] = color; end
                end else if (pos[i] == flen(i) - 1) begin
                    mfc[i] = mfc[i] + 8'd1;
                    pos[i] = 0;
                    if (EN) begin sm[i] = mode; sc[i] = color; end
                    else run[i] = 0;
                end else begin
                    pos[i] = pos[i] + 1;
                end
                expv[i].fc = mfc[i];
            end
        end
    end

    // ---------------- checking helpers ----------------
    int          n_chk = 0;
    int          n_fail = 0;
    int          fidx [2] = '{-1, -1};
    int          px   [2] = '{0, 0};
    logic        pvs  [2] = '{1'b0, 1'b0};
    logic [15:0] cap  [2][2][8][18];
    vec_t        vt [64];
    int          nv = 0;

    task automatic check(string name, logic [31:0] got, logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
        end
    endtask

    // One cycle: compare against the model and capture active pixels
    task automatic tick();
        int x, y;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check(i ? "model1" : "model0", 32'(act[i]), 32'(expv[i]));
            if (!rst_n) begin
                fidx[i] = -1;
                px[i]   = 0;
            end else begin
                if (act[i].vs && !pvs[i]) begin fidx[i]++; px[i] = 0; end
                if (act[i].de) begin
                    x = px[i] % hdisp(i);
                    y = px[i] / hdisp(i);
                    if (fidx[i] >= 0 && fidx[i] < 2 && y < 8) cap[i][fidx[i]][y][x] = act[i].data;
                    px[i]++;
                end
            end
            pvs[i] = act[i].vs;
        end
        if (!rst_n)
            for (int a = 0; a < 2; a++) for (int b = 0; b < 2; b++)
                for (int c = 0; c < 8; c++) for (int d = 0; d < 18; d++) cap[a][b][c][d] = 'x;
    endtask

    // kind: 0 de=1, 1 vs=1, 2 fc==val, 3 fc!=val
    task automatic wait_cond(int inst, int kind, int val, int limit, string name);
        bit hit = 0;
        for (int k = 0; k < limit && !hit; k++) begin
            tick();
            case (kind)
                0: hit = act[inst].de;
                1: hit = act[inst].vs;
                2: hit = (act[inst].fc == 8'(val));
                default: hit = (act[inst].fc != 8'(val));
            endcase
        end
        n_chk++;
        if (!hit) begin
            n_fail++;
            $display("FAIL %s: got no event in %0d cycles, expected event", name, limit);
        end
    endtask

    task automatic addv(logic [1:0] m, int inst, int fr, int x, int y, logic [15:0] e);
        vt[nv] = '{m, inst, fr, x, y, e};
        nv++;
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int nvs, nhs, nde, bad;

        addv(0, 0, 0, 0, 0, 16'h1234);  addv(0, 0, 1, 15, 3, 16'h1234);
        addv(0, 1, 0, 17, 7, 16'h1234);
        addv(1, 0, 0, 0, 0, 16'hFFFF);  addv(1, 0, 0, 1, 0, 16'hFFFF);
        addv(1, 0, 0, 2, 0, 16'hFFE0);  addv(1, 0, 0, 3, 0, 16'hFFE0);
        addv(1, 0, 0, 4, 0, 16'h07FF);  addv(1, 0, 0, 6, 0, 16'h07E0);
        addv(1, 0, 0, 8, 0, 16'hF81F);  addv(1, 0, 0, 10, 0, 16'hF800);
        addv(1, 0, 0, 12, 0, 16'h001F); addv(1, 0, 0, 14, 0, 16'h0000);
        addv(1, 0, 0, 15, 0, 16'h0000); addv(1, 0, 1, 5, 3, 16'h07FF);
        addv(1, 1, 0, 12, 0, 16'h001F); addv(1, 1, 0, 13, 0, 16'h001F);
        addv(1, 1, 0, 14, 0, 16'h0000); addv(1, 1, 0, 17, 5, 16'h0000);
        addv(2, 0, 0, 8, 0, 16'h0841);  addv(2, 0, 0, 15, 2, 16'h0861);
        addv(2, 0, 0, 4, 1, 16'h0020);  addv(2, 0, 0, 0, 0, 16'h0000);
        addv(2, 1, 1, 17, 6, 16'h1082);
        addv(3, 0, 0, 0, 0, 16'hFFFF);  addv(3, 0, 0, 3, 0, 16'hFFFF);
        addv(3, 0, 0, 4, 0, 16'h0000);  addv(3, 0, 0, 7, 0, 16'h0000);
        addv(3, 0, 0, 8, 0, 16'hFFFF);  addv(3, 0, 1, 0, 0, 16'hFFFF);
        addv(3, 0, 1, 2, 0, 16'hFFFF);  addv(3, 0, 1, 3, 0, 16'h0000);
        addv(3, 0, 1, 6, 0, 16'h0000);  addv(3, 0, 1, 7, 0, 16'hFFFF);
        addv(3, 0, 1, 3, 3, 16'h0000);  addv(3, 1, 0, 0, 0, 16'hFFFF);
        addv(3, 1, 0, 0, 4, 16'h0000);  addv(3, 1, 0, 4, 4, 16'hFFFF);
        addv(3, 1, 0, 15, 0, 16'h0000); addv(3, 1, 0, 16, 0, 16'hFFFF);
        addv(3, 1, 1, 2, 4, 16'h0000);  addv(3, 1, 1, 3, 4, 16'hFFFF);
        addv(3, 1, 1, 17, 0, 16'hFFFF);

        // Reset, then enable solid 1234 and measure one full frame
        repeat (3) tick();
        check("reset_outs0", 32'(act[0]), 32'd0);
        check("reset_outs1", 32'(act[1]), 32'd0);
        rst_n = 1'b1; EN = 1'b1; mode = 2'b00; color = 16'h1234;
        wait_cond(0, 1, 0, 400, "first_vs");
        nvs = 0; nhs = 0; nde = 0; bad = 0;
        for (int k = 0; k < 154; k++) begin
            if (k > 0) tick();
            nvs += int'(act[0].vs);
            nhs += int'(act[0].hs);
            nde += int'(act[0].de);
            if (act[0].de && act[0].data !== 16'h1234) bad++;
            if (!act[0].de && act[0].data !== 16'h0000) bad++;
        end
        check("frame_vs_clocks", 32'(nvs), 32'd22);
        check("frame_hs_clocks", 32'(nhs), 32'd14);
        check("frame_de_pulses", 32'(nde), 32'd64);
        check("frame_data_bad", 32'(bad), 32'd0);

        // Captured-pixel vector table, one run per pattern mode
        for (int m = 0; m < 4; m++) begin
            rst_n = 1'b0;
            tick(); tick();
            rst_n = 1'b1; mode = 2'(m); color = 16'h1234; EN = 1'b1;
            repeat (600) tick();
            for (int k = 0; k < nv; k++)
                if (vt[k].mode == 2'(m))
                    check($sformatf("vec%0d_m%0d_i%0d_f%0d_x%0d_y%0d", k, m, vt[k].inst, vt[k].fr, vt[k].x, vt[k].y),
                          32'(cap[vt[k].inst][vt[k].fr][vt[k].y][vt[k].x]), 32'(vt[k].exp));
        end

        // Shadowing: mode change and EN drop mid-frame
        rst_n = 1'b0;
        tick(); tick();
        rst_n = 1'b1; mode = 2'b00; color = 16'hABCD; EN = 1'b1;
        wait_cond(0, 0, 0, 400, "shadow_first_de");
        mode = 2'b01; EN = 1'b0;
        nde = 0; bad = 0;
        for (int k = 0; k < 200; k++) begin
            tick();
            if (act[0].de) begin
                nde++;
                if (act[0].data !== 16'hABCD) bad++;
            end
        end
        check("shadow_de_rest", 32'(nde), 32'd63);
        check("shadow_data_bad", 32'(bad), 32'd0);
        check("shadow_fc", 32'(act[0].fc), 32'd1);
        nde = 0;
        for (int k = 0; k < 300; k++) begin
            tick();
            nde += int'(act[0].de) + int'(act[1].de);
        end
        check("idle_no_de", 32'(nde), 32'd0);
        check("idle_fc0", 32'(act[0].fc), 32'd1);
        check("idle_fc1", 32'(act[1].fc), 32'd1);
        EN = 1'b1;
        tick();
        check("reen_vs_edge1", 32'(act[0].vs), 32'd0);
        tick();
        check("reen_vs_edge2", 32'(act[0].vs), 32'd1);

        // Randomized traffic against the model
        for (int k = 0; k < 3000; k++) begin
            rst_n = ($urandom_range(0, 499) != 0);
            EN    = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 3) == 0) mode = 2'($urandom);
            color = 16'($urandom);
            tick();
        end

        // Reset during an active line, then run to frame_cnt wrap
        rst_n = 1'b1; EN = 1'b1; mode = 2'b11;
        wait_cond(0, 0, 0, 400, "midrst_de");
        rst_n = 1'b0;
        tick();
        check("midrst_outs0", 32'(act[0]), 32'd0);
        check("midrst_outs1", 32'(act[1]), 32'd0);
        rst_n = 1'b1;
        wait_cond(0, 2, 255, 256 * 154 + 400, "reach_fc255");
        wait_cond(0, 3, 255, 200, "leave_fc255");
        check("fc_wrap", 32'(act[0].fc), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
